// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_RD     = 2;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on clear_req,
// and raises ready once the whole file has been swept.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready     = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        // Last entry swept: index wraps to 0, ready on the following cycle.
        if (clr_idx_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports, hard-zero
// option and a sequenced clear. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_req,
  output logic                         ready,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        wa0,
  input  logic [DATA_WIDTH-1:0]        wd0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        wa1,
  input  logic [DATA_WIDTH-1:0]        wd1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr0_act, wr1_act;
  logic                  wr0_en, wr1_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  reg_file_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // "act" is a write the pipeline is presenting; "en" is one that actually
  // commits, which a same-cycle clear_req suppresses.
  always_comb begin
    wr0_act = we0 && ready && !((ZERO_REG != 0) && (wa0 == '0));
    wr1_act = we1 && ready && !((ZERO_REG != 0) && (wa1 == '0));
    wr0_en  = wr0_act && !clear_req;
    wr1_en  = wr1_act && !clear_req;
  end

  // No reset on the array so it stays RAM-inferable; port 1 is written last and wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr0_en) mem[wa0] <= wd0;
      if (wr1_en) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] val;

    assign addr = ra[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      val = mem[addr];
`ifdef REG_FILE_BYPASS_EN
      if (wr0_act && (wa0 == addr)) val = wd0;
      if (wr1_act && (wa1 == addr)) val = wd1;
`endif
      if (!ready || ((ZERO_REG != 0) && (addr == '0))) val = '0;
    end

    assign rd[k*DATA_WIDTH +: DATA_WIDTH] = val;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, clear/reset
// sequences and randomized traffic against a behavioural model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   clear_req = 1'b0;
  logic                   we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]          wa0 = '0, wa1 = '0;
  logic [DW-1:0]          wd0 = '0, wd1 = '0;
  logic [NR-1:0][AW-1:0]  ra = '0;
  logic [NR-1:0][DW-1:0]  rd_z, rd_n;
  logic                   ready_z, ready_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_z),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_z)
  );

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_n)
  );

  // Reference model: busy countdown plus two plain arrays (hard-zero and ordinary).
  logic [DW-1:0] mz [DEPTH];
  logic [DW-1:0] mn [DEPTH];
  bit            m_ready;
  int            m_left;

  task automatic model_start_clear();
    m_ready = 1'b0;
    m_left  = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      mz[i] = '0;
      mn[i] = '0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_start_clear();
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (clear_req) begin
      model_start_clear();
    end else begin
      if (we0) begin
        if (wa0 != 0) mz[wa0] = wd0;
        mn[wa0] = wd0;
      end
      if (we1) begin
        if (wa1 != 0) mz[wa1] = wd1;
        mn[wa1] = wd1;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(bit zr, logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!m_ready) return '0;
    if (zr && a == 0) return '0;
    v = zr ? mz[a] : mn[a];
    if (BYP) begin
      if (we0 && !(zr && wa0 == 0) && wa0 == a) v = wd0;
      if (we1 && !(zr && wa1 == 0) && wa1 == a) v = wd1;
    end
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ready_z", 32'(ready_z), 32'(m_ready));
    chk("ready_nz", 32'(ready_n), 32'(m_ready));
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd_z[%0d] a=%0d", k, ra[k]), rd_z[k], exp_rd(1'b1, ra[k]));
      chk($sformatf("rd_nz[%0d] a=%0d", k, ra[k]), rd_n[k], exp_rd(1'b0, ra[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step(bit do_chk);
    #1;
    if (do_chk) check_model();
    tick();
  endtask

  task automatic wait_ready(string name, int exp_n);
    int n = 0;
    while (!ready_z && n < 200) begin
      step(1'b1);
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; clear_req = 1'b0;
  endtask

  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1, enz0;
  } vec_t;

  function automatic vec_t mkv(int w0, int a0, int d0, int w1, int a1, int d1,
                               int r0, int r1, int x0, int x1, int xn);
    vec_t v;
    v.we0 = 1'(w0);  v.wa0 = AW'(a0); v.wd0 = DW'(d0);
    v.we1 = 1'(w1);  v.wa1 = AW'(a1); v.wd1 = DW'(d1);
    v.ra0 = AW'(r0); v.ra1 = AW'(r1);
    v.e0 = DW'(x0);  v.e1 = DW'(x1);  v.enz0 = DW'(xn);
    return v;
  endfunction

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b;
    b = BYP ? 1 : 0;
    // Expected values assume a freshly cleared file (all zero) and ZERO_REG=1 on dut.
    vecs[0]  = mkv(1,7,'hAAAA, 1,7,'h5555, 7,7, b?'h5555:0, b?'h5555:0, b?'h5555:0);
    vecs[1]  = mkv(1,3,'h11,   1,9,'h22,   7,7, 'h5555, 'h5555, 'h5555);
    vecs[2]  = mkv(0,0,0,      0,0,0,      3,9, 'h11, 'h22, 'h11);
    vecs[3]  = mkv(1,0,'hFFFF, 0,0,0,      0,3, 0, 'h11, b?'hFFFF:0);
    vecs[4]  = mkv(0,0,0,      0,0,0,      0,0, 0, 0, 'hFFFF);
    vecs[5]  = mkv(1,4,'hDEAD, 0,0,0,      4,9, b?'hDEAD:0, 'h22, b?'hDEAD:0);
    vecs[6]  = mkv(0,0,0,      0,0,0,      4,4, 'hDEAD, 'hDEAD, 'hDEAD);
    vecs[7]  = mkv(1,5,'h1234, 1,4,'hBEEF, 4,5, b?'hBEEF:'hDEAD, b?'h1234:0, b?'hBEEF:'hDEAD);
    vecs[8]  = mkv(0,0,0,      0,0,0,      4,5, 'hBEEF, 'h1234, 'hBEEF);
    vecs[9]  = mkv(1,8,'h1,    1,8,'h2,    8,8, b?2:0, b?2:0, b?2:0);
    vecs[10] = mkv(0,0,0,      0,0,0,      8,0, 2, 0, 2);

    // Reset state, then clear length; a write to x5 during the sweep must vanish.
    repeat (3) @(negedge clk);
    model_start_clear();
    #1;
    chk("reset_ready", 32'(ready_z), 32'(0));
    we0 = 1'b1; wa0 = 5; wd0 = 32'h5555_0005;
    ra[0] = 5; ra[1] = 5;
    rst = 1'b0;
    wait_ready("clr_len_after_rst", DEPTH);
    idle_inputs();
    #1;
    chk("x5_after_clear", rd_z[0], 32'h0);
    tick();

    // Directed vector table
    foreach (vecs[i]) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      ra[0] = vecs[i].ra0; ra[1] = vecs[i].ra1;
      #1;
      chk($sformatf("vec%0d rd0", i), rd_z[0], vecs[i].e0);
      chk($sformatf("vec%0d rd1", i), rd_z[1], vecs[i].e1);
      chk($sformatf("vec%0d nz_rd0", i), rd_n[0], vecs[i].enz0);
      tick();
    end
    idle_inputs();

    // Fill x1..x31, then clear_req together with a write to x2
    for (int i = 1; i < DEPTH; i++) begin
      we0 = 1'b1; wa0 = AW'(i); wd0 = 32'h0101_0000 + 32'(i);
      ra[0] = AW'(i); ra[1] = AW'(i - 1);
      step(1'b1);
    end
    we0 = 1'b1; wa0 = 2; wd0 = 32'h7777; clear_req = 1'b1;
    ra[0] = 2; ra[1] = 31;
    #1;
    chk("ready_in_req_cycle", 32'(ready_z), 32'(1));
    chk("x31_before_clear", rd_z[1], 32'h0101_001F);
    tick();
    idle_inputs();
    chk("ready_fell_after_req", 32'(ready_z), 32'(0));
    wait_ready("clr_len_after_req", DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      ra[0] = AW'(i); ra[1] = AW'(i);
      #1;
      chk($sformatf("cleared_x%0d", i), rd_z[0], 32'h0);
      chk($sformatf("cleared_nz_x%0d", i), rd_n[1], 32'h0);
      tick();
    end

    // rst in the middle of a clear restarts the full sweep
    clear_req = 1'b1;
    step(1'b1);
    clear_req = 1'b0;
    repeat (10) step(1'b1);
    rst = 1'b1;
    model_start_clear();
    #1;
    chk("ready_low_in_rst", 32'(ready_z), 32'(0));
    tick();
    rst = 1'b0;
    wait_ready("clr_len_restart", DEPTH);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom_range(0, DEPTH - 1));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, DEPTH - 1));
      wd0 = $urandom;
      wd1 = $urandom;
      clear_req = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NR; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom_range(0, DEPTH - 1));
      step(1'b1);
    end
    idle_inputs();
    wait_ready("final_settle", 0 + (ready_z ? 0 : m_left));

    // Asynchronous reset away from any clock edge drops ready at once
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(ready_z), 32'(0));
    chk("async_rst_rd", rd_n[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
